bldc_commutator: RTL and testbench

Hall-synchronous six-step BLDC commutation controller. It replaces open-loop state stepping on a divided clock with closed-loop commutation from filtered hall inputs, and adds PWM high-side chopping, programmable dead-time, fault latching and commutation-period measurement. It sits between the speed/ADC front end (which supplies `duty`) and the 3-phase transistor array outputs.

---
 rtl/bldc_commutator.sv | 280 ++++++++++++++++++++++++++++
 tb/tb_bldc_commutator.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/bldc_commutator.sv
// bldc_commutator
//   Hall-synchronous six-step BLDC commutation controller. Filters the raw
//   hall inputs into a sector, maps the sector (and rotation direction) to a
//   six-transistor drive pattern, chops the high sides with a PWM carrier,
//   inserts all-off dead time on every pattern change, latches invalid-hall
//   and stall faults, and measures the commutation period.
//
// Ports
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   enable       drive enable (level)
//   fwd          1 = forward rotation, 0 = reverse
//   duty         high-side on-time; 0 = off, all-ones = 100%
//   hall         raw hall inputs {H2,H1,H0}, asynchronous
//   clear_fault  single-cycle fault clear (honoured only with enable=0)
//   phase_out    {A+,A-,B+,B-,C+,C-}, active high
//   fault        latched fault flag
//   fault_code   0 = none, 1 = invalid hall code, 2 = stall
//   comm_period  clk cycles between the last two accepted sector changes
//   period_valid one-cycle pulse when comm_period updates

module bldc_commutator #(
  parameter int unsigned PWM_BITS     = 12,
  parameter int unsigned DEAD_CYCLES  = 50,
  parameter int unsigned HALL_FILTER  = 4,
  parameter int unsigned STALL_CYCLES = 50000000,
  parameter int unsigned PERIOD_BITS  = 24
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   enable,
  input  logic                   fwd,
  input  logic [PWM_BITS-1:0]    duty,
  input  logic [2:0]             hall,
  input  logic                   clear_fault,
  output logic [5:0]             phase_out,
  output logic                   fault,
  output logic [1:0]             fault_code,
  output logic [PERIOD_BITS-1:0] comm_period,
  output logic                   period_valid
);

  localparam int unsigned HF_W    = $clog2(HALL_FILTER + 1);
  localparam int unsigned DEAD_W  = $clog2(DEAD_CYCLES + 1);
  localparam int unsigned STALL_W = $clog2(STALL_CYCLES + 1);

  localparam logic [HF_W-1:0]     HF_MAX     = HF_W'(HALL_FILTER);
  localparam logic [DEAD_W-1:0]   DEAD_LAST  = DEAD_W'(DEAD_CYCLES - 1);
  localparam logic [STALL_W-1:0]  STALL_LAST = STALL_W'(STALL_CYCLES - 1);
  localparam logic [PWM_BITS-1:0] CAR_LAST   = {{(PWM_BITS-1){1'b1}}, 1'b0};

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DEAD,
    ST_RUN,
    ST_FAULT
  } state_t;

  function automatic logic [5:0] pattern(input logic [2:0] idx);
    case (idx)
      3'd0:    pattern = 6'b100001;
      3'd1:    pattern = 6'b100100;
      3'd2:    pattern = 6'b000110;
      3'd3:    pattern = 6'b010010;
      3'd4:    pattern = 6'b011000;
      3'd5:    pattern = 6'b001001;
      default: pattern = '0;
    endcase
  endfunction

  // ---------------- hall synchroniser and filter ----------------
  logic [2:0]      hall_s1, hall_s2;
  logic [1:0]      sync_fill;
  logic [2:0]      cand;
  logic [HF_W-1:0] stable_cnt, cnt_nxt;
  logic            same, acc_evt;
  logic [2:0]      evt_idx;
  logic            evt_ok;

  // sync_fill keeps the reset value of the synchroniser from being counted
  // as a real hall code.
  always_comb begin
    same    = (hall_s2 == cand);
    cnt_nxt = HF_W'(1);
    if (same) cnt_nxt = (stable_cnt == HF_MAX) ? stable_cnt : stable_cnt + 1'b1;
    acc_evt = sync_fill[1] && (cnt_nxt == HF_MAX) && !(same && stable_cnt == HF_MAX);
  end

  always_comb begin
    evt_ok  = 1'b1;
    evt_idx = 3'd0;
    case (hall_s2)
      3'b001:  evt_idx = 3'd0;
      3'b000:  evt_idx = 3'd1;
      3'b100:  evt_idx = 3'd2;
      3'b110:  evt_idx = 3'd3;
      3'b111:  evt_idx = 3'd4;
      3'b011:  evt_idx = 3'd5;
      default: evt_ok  = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hall_s1    <= '0;
      hall_s2    <= '0;
      sync_fill  <= '0;
      cand       <= '0;
      stable_cnt <= '0;
    end else begin
      hall_s1   <= hall;
      hall_s2   <= hall_s1;
      sync_fill <= {sync_fill[0], 1'b1};
      if (sync_fill[1]) begin
        cand       <= hall_s2;
        stable_cnt <= cnt_nxt;
      end
    end
  end

  // ---------------- accepted sector ----------------
  logic [2:0] sector;
  logic       sector_vld;
  logic       hall_bad;
  logic       sec_chg;

  assign sec_chg = acc_evt && evt_ok && (!sector_vld || evt_idx != sector);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sector     <= '0;
      sector_vld <= 1'b0;
      hall_bad   <= 1'b0;
    end else if (acc_evt) begin
      hall_bad <= !evt_ok;
      if (evt_ok) begin
        sector     <= evt_idx;
        sector_vld <= 1'b1;
      end else begin
        sector_vld <= 1'b0;
      end
    end
  end

  logic [2:0] tgt_idx;
  logic [5:0] target;

  always_comb begin
    tgt_idx = sector;
    if (!fwd) tgt_idx = (sector >= 3'd3) ? sector - 3'd3 : sector + 3'd3;
    target = pattern(tgt_idx);
  end

  // ---------------- PWM carrier ----------------
  logic [PWM_BITS-1:0] carrier;
  logic                hs_on;

  assign hs_on = (duty == '1) || (carrier < duty);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  carrier <= '0;
    else if (carrier == CAR_LAST) carrier <= '0;
    else                          carrier <= carrier + 1'b1;
  end

  // ---------------- stall detection and fault latch ----------------
  state_t             state, state_nxt;
  logic [STALL_W-1:0] stall_cnt;
  logic               stall_run, stall_hit, fault_set, fault_clr;

  assign stall_run = (state == ST_RUN) && (duty != '0);
  assign stall_hit = stall_run && !sec_chg && (stall_cnt == STALL_LAST);
  assign fault_set = !fault && (hall_bad || stall_hit);
  assign fault_clr = (state == ST_FAULT) && clear_fault && !enable;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                    stall_cnt <= '0;
    else if (!stall_run || sec_chg) stall_cnt <= '0;
    else if (!stall_hit)            stall_cnt <= stall_cnt + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fault      <= 1'b0;
      fault_code <= 2'd0;
    end else if (fault_clr) begin
      fault      <= 1'b0;
      fault_code <= 2'd0;
    end else if (fault_set) begin
      fault      <= 1'b1;
      fault_code <= hall_bad ? 2'd1 : 2'd2;
    end
  end

  // ---------------- commutation FSM ----------------
  logic [5:0]        latched, latched_nxt, phase_nxt;
  logic [DEAD_W-1:0] dead_cnt, dead_nxt;

  always_comb begin
    state_nxt   = state;
    latched_nxt = latched;
    dead_nxt    = dead_cnt;
    case (state)
      ST_IDLE: begin
        if (enable && !fault && sector_vld) begin
          state_nxt   = ST_DEAD;
          latched_nxt = target;
          dead_nxt    = '0;
        end
      end
      ST_DEAD: begin
        if (!enable) begin
          state_nxt = ST_IDLE;
        end else if (target != latched) begin
          latched_nxt = target;
          dead_nxt    = '0;
        end else if (dead_cnt == DEAD_LAST) begin
          state_nxt = ST_RUN;
        end else begin
          dead_nxt = dead_cnt + 1'b1;
        end
      end
      ST_RUN: begin
        if (!enable) begin
          state_nxt = ST_IDLE;
        end else if (target != latched) begin
          state_nxt   = ST_DEAD;
          latched_nxt = target;
          dead_nxt    = '0;
        end
      end
      ST_FAULT: begin
        if (fault_clr) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
    if (fault_set) state_nxt = ST_FAULT;

    // Output is registered from the next state so that leaving RUN blanks
    // the bridge on the same edge the decision is taken.
    phase_nxt = '0;
    if (state_nxt == ST_RUN)
      phase_nxt = {latched_nxt[5] & hs_on, latched_nxt[4],
                   latched_nxt[3] & hs_on, latched_nxt[2],
                   latched_nxt[1] & hs_on, latched_nxt[0]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      latched   <= '0;
      dead_cnt  <= '0;
      phase_out <= '0;
    end else begin
      state     <= state_nxt;
      latched   <= latched_nxt;
      dead_cnt  <= dead_nxt;
      phase_out <= phase_nxt;
    end
  end

  // ---------------- commutation period ----------------
  logic [PERIOD_BITS-1:0] period_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      period_cnt   <= '0;
      comm_period  <= '0;
      period_valid <= 1'b0;
    end else if (sec_chg) begin
      comm_period  <= period_cnt;
      period_valid <= 1'b1;
      period_cnt   <= PERIOD_BITS'(1);
    end else begin
      period_valid <= 1'b0;
      if (period_cnt != '1) period_cnt <= period_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_bldc_commutator.sv
// tb_bldc_commutator
//   Directed bench for bldc_commutator with PWM_BITS=4, DEAD_CYCLES=4,
//   HALL_FILTER=3, STALL_CYCLES=1000. Inputs change right after a falling
//   edge; outputs are sampled on falling edges.

module tb_bldc_commutator;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic        fwd = 1'b1;
  logic [3:0]  duty = '0;
  logic [2:0]  hall = '0;
  logic        clear_fault = 1'b0;
  logic [5:0]  phase_out;
  logic        fault;
  logic [1:0]  fault_code;
  logic [23:0] comm_period;
  logic        period_valid;

  int total = 0;
  int bad   = 0;
  int ap, am, bm;

  bldc_commutator #(
    .PWM_BITS    (4),
    .DEAD_CYCLES (4),
    .HALL_FILTER (3),
    .STALL_CYCLES(1000),
    .PERIOD_BITS (24)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .fwd         (fwd),
    .duty        (duty),
    .hall        (hall),
    .clear_fault (clear_fault),
    .phase_out   (phase_out),
    .fault       (fault),
    .fault_code  (fault_code),
    .comm_period (comm_period),
    .period_valid(period_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_clear();
    clear_fault = 1'b1;
    tick(1);
    clear_fault = 1'b0;
  endtask

  // A+/A-, B+/B-, C+/C- must never be on together.
  always @(negedge clk)
    if (rst_n)
      chk("shoot", int'({phase_out[5] & phase_out[4],
                         phase_out[3] & phase_out[2],
                         phase_out[1] & phase_out[0]}), 0);

  initial begin
    // 1: start-up from reset with hall=001 forward
    enable = 1'b1; fwd = 1'b1; duty = 4'd15; hall = 3'b001;
    tick(2);
    rst_n = 1'b1;
    chk("rst_phase", int'(phase_out), 0);
    chk("rst_fault", int'(fault), 0);
    chk("rst_code", int'(fault_code), 0);
    chk("rst_period", int'(comm_period), 0);
    chk("rst_pv", int'(period_valid), 0);
    tick(9);
    chk("t1_dead", int'(phase_out), 0);
    tick(1);
    chk("t1_run", int'(phase_out), 'b100001);
    tick(10);

    // 2: 001 -> 000 twenty edges after the first acceptance
    hall = 3'b000;
    tick(4);
    chk("t2_pv_early", int'(period_valid), 0);
    chk("t2_old", int'(phase_out), 'b100001);
    tick(1);
    chk("t2_pv", int'(period_valid), 1);
    chk("t2_period", int'(comm_period), 20);
    tick(1);
    chk("t2_dead0", int'(phase_out), 0);
    chk("t2_pv_once", int'(period_valid), 0);
    tick(3);
    chk("t2_dead3", int'(phase_out), 0);
    tick(1);
    chk("t2_s2", int'(phase_out), 'b100100);
    tick(20);
    hall = 3'b100;
    tick(5);
    chk("t2_pv2", int'(period_valid), 1);
    chk("t2_period2", int'(comm_period), 30);
    tick(5);
    chk("t2_s3", int'(phase_out), 'b000110);

    // 3: reverse rotation, then fwd toggled while running
    enable = 1'b0;
    tick(1);
    chk("t3_off", int'(phase_out), 0);
    fwd = 1'b0; hall = 3'b001; enable = 1'b1;
    tick(20);
    chk("t3_rev", int'(phase_out), 'b010010);
    fwd = 1'b1;
    tick(1);
    chk("t3_dead0", int'(phase_out), 0);
    tick(3);
    chk("t3_dead3", int'(phase_out), 0);
    tick(1);
    chk("t3_fwd", int'(phase_out), 'b100001);

    // 4: chopping at duty=5 and duty=0 in S2
    enable = 1'b0;
    tick(1);
    hall = 3'b000; duty = 4'd5; enable = 1'b1;
    tick(20);
    ap = 0; am = 0; bm = 0;
    for (int i = 0; i < 30; i++) begin
      tick(1);
      ap += int'(phase_out[5]);
      am += int'(phase_out[4]);
      bm += int'(phase_out[2]);
    end
    chk("t4_ap", ap, 10);
    chk("t4_am", am, 0);
    chk("t4_bm", bm, 30);
    duty = 4'd0;
    tick(2);
    ap = 0; bm = 0;
    for (int i = 0; i < 15; i++) begin
      tick(1);
      ap += int'(phase_out[5]);
      bm += int'(phase_out[2]);
    end
    chk("t4_ap_zero", ap, 0);
    chk("t4_bm_zero", bm, 15);

    // 5: glitch rejection, invalid-hall fault and clearing
    enable = 1'b0;
    tick(1);
    hall = 3'b001; duty = 4'd15; enable = 1'b1;
    tick(20);
    chk("t5_run", int'(phase_out), 'b100001);
    hall = 3'b101;
    tick(2);
    hall = 3'b001;
    tick(10);
    chk("t5_glitch_fault", int'(fault), 0);
    chk("t5_glitch_phase", int'(phase_out), 'b100001);
    hall = 3'b101;
    tick(4);
    chk("t5_pre_fault", int'(fault), 0);
    tick(3);
    chk("t5_fault", int'(fault), 1);
    chk("t5_code", int'(fault_code), 1);
    chk("t5_phase", int'(phase_out), 0);
    pulse_clear();
    tick(1);
    chk("t5_clr_ign", int'(fault), 1);
    chk("t5_clr_ign_code", int'(fault_code), 1);
    hall = 3'b001; enable = 1'b0;
    tick(8);
    pulse_clear();
    chk("t5_cleared", int'(fault), 0);
    chk("t5_cleared_code", int'(fault_code), 0);
    tick(3);
    chk("t5_stay_clear", int'(fault), 0);
    // clear while an invalid code is still accepted
    hall = 3'b010;
    tick(8);
    chk("t5_idle_fault", int'(fault), 1);
    pulse_clear();
    chk("t5_reclr", int'(fault), 0);
    tick(1);
    chk("t5_reassert", int'(fault), 1);
    chk("t5_reassert_code", int'(fault_code), 1);
    hall = 3'b001;
    tick(8);
    pulse_clear();
    chk("t5_final_clr", int'(fault), 0);

    // 6: stall with frozen hall, then async reset mid-PWM
    duty = 4'd8; enable = 1'b1;
    tick(995);
    chk("t6_no_stall", int'(fault), 0);
    tick(20);
    chk("t6_stall", int'(fault), 1);
    chk("t6_code", int'(fault_code), 2);
    chk("t6_phase", int'(phase_out), 0);
    enable = 1'b0;
    pulse_clear();
    chk("t6_clr", int'(fault), 0);
    enable = 1'b1;
    tick(10);
    chk("t6_rerun_cm", int'(phase_out[0]), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_async", int'(phase_out), 0);
    chk("t6_async_fault", int'(fault), 0);
    tick(2);
    rst_n = 1'b1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
